// File: rtl/axis_width_down.sv
// axis_width_down: splits each wide AXI-Stream beat into RATIO narrow beats, skipping empty upper slices
module axis_width_down #(
  parameter int M_DATA_W = 256,
  parameter int RATIO = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [M_DATA_W*RATIO-1:0]    s_axis_tdata,
  input  logic [M_DATA_W*RATIO/8-1:0]  s_axis_tkeep,
  input  logic                         s_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [M_DATA_W-1:0]          m_axis_tdata,
  output logic [M_DATA_W/8-1:0]        m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic [15:0]                  drop_cnt
);
  localparam int S_DATA_W = M_DATA_W*RATIO;
  localparam int M_KEEP_W = M_DATA_W/8;
  localparam int IDX_W = $clog2(RATIO);
  logic [S_DATA_W-1:0] r_data;
  logic [S_DATA_W/8-1:0] r_keep;
  logic r_last, r_full;
  logic [IDX_W-1:0] r_idx, r_hi, w_hi;
  logic [15:0] r_drop;
  logic [M_DATA_W-1:0] w_dsl [RATIO];
  logic [M_KEEP_W-1:0] w_ksl [RATIO];
  logic w_last_sl, w_acc, w_drop;
  for (genvar i = 0; i < RATIO; i++) begin : g_sl
    assign w_dsl[i] = r_data[i*M_DATA_W +: M_DATA_W];
    assign w_ksl[i] = r_keep[i*M_KEEP_W +: M_KEEP_W];
  end
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < RATIO; i++)
      if (|s_axis_tkeep[i*M_KEEP_W +: M_KEEP_W]) w_hi = IDX_W'(i);
  end
  assign w_last_sl = r_idx == r_hi;
  assign m_axis_tvalid = r_full;
  assign m_axis_tdata = w_dsl[r_idx];
  assign m_axis_tkeep = w_ksl[r_idx];
  assign m_axis_tlast = r_full & r_last & w_last_sl;
  assign s_axis_tready = ~reset & (~r_full | (m_axis_tready & w_last_sl));
  assign w_acc = s_axis_tvalid & s_axis_tready;
  assign w_drop = ~|s_axis_tkeep & ~s_axis_tlast;
  assign drop_cnt = r_drop;
  always_ff @(posedge clk)
    if (reset) begin
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_full <= 1'b0;
      r_idx <= '0;
      r_hi <= '0;
      r_drop <= '0;
    end else if (w_acc) begin
      r_full <= ~w_drop;
      r_idx <= '0;
      if (w_drop) r_drop <= r_drop + 16'(r_drop != 16'hFFFF);
      else begin
        r_data <= s_axis_tdata;
        r_keep <= s_axis_tkeep;
        r_last <= s_axis_tlast;
        r_hi <= w_hi;
      end
    end else if (m_axis_tvalid & m_axis_tready) begin
      r_full <= ~w_last_sl;
      r_idx <= w_last_sl ? '0 : r_idx + 1'b1;
    end
endmodule
